// File: rtl/uart_msg_tx.sv
// uart_msg_tx: sends a latched packed message as back-to-back async serial frames
//   clk, reset      : single clock, synchronous active-high reset
//   start           : send request, honoured only when idle
//   msg, msg_len    : packed message (top slice first) and character count
//   txd_pin         : serial line, idles high
//   busy, done      : in-progress flag and one-cycle completion pulse
//   led             : [0] busy, [1] sticky done, [2] per-character toggle, [3] sticky NUL stop
module uart_msg_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MSG_BYTES    = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int NUL_STOP     = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [MSG_BYTES*DATA_BITS-1:0]       msg,
    input  logic [$clog2(MSG_BYTES+1)-1:0]       msg_len,
    output logic                                 txd_pin,
    output logic                                 busy,
    output logic                                 done,
    output logic [3:0]                           led
);
    localparam int LW = $clog2(MSG_BYTES + 1);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int MW = MSG_BYTES * DATA_BITS;
    localparam logic [LW-1:0] MAX_LEN = LW'(MSG_BYTES);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP, NEXT, FINISH} state_t;

    state_t               state, state_next;
    logic [MW-1:0]        msg_q;
    logic [LW-1:0]        len_q, idx;
    logic [DATA_BITS-1:0] shreg;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_cnt;
    logic                 par, tick, nul, last, abort;

    // msg_q is shifted left as characters are consumed, so its top slice is always the next character
    assign tick  = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign nul   = NUL_STOP != 0 && msg_q[MW-1 -: DATA_BITS] == '0;
    assign last  = state == LOAD ? len_q == '0 : LW'(idx + 1'b1) == len_q;
    assign abort = (state == LOAD || state == NEXT) && !last && nul;

    // NEXT occupies the final cycle of the last stop bit, keeping frames back-to-back
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = start ? LOAD : IDLE;
            LOAD, NEXT: state_next = last || nul ? FINISH : START;
            START:      state_next = tick ? DATA : START;
            DATA:       state_next = tick && bit_cnt == 3'(DATA_BITS - 1) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
            PARITY:     state_next = tick ? STOP : PARITY;
            STOP:       state_next = clk_cnt == CW'(CLKS_PER_BIT - 2) && bit_cnt == 3'(STOP_BITS - 1) ? NEXT : STOP;
            default:    state_next = IDLE;
        endcase
    end

    // outputs are registered from the current state, so the line trails the FSM by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            msg_q   <= '0;
            len_q   <= '0;
            idx     <= '0;
            shreg   <= '0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            txd_pin <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            led     <= '0;
        end else begin
            state   <= state_next;
            clk_cnt <= tick || !(state inside {START, DATA, PARITY, STOP}) ? '0 : clk_cnt + 1'b1;
            bit_cnt <= state_next != state ? '0 : bit_cnt + 3'(tick);
            if (state == IDLE && start) begin
                msg_q  <= msg;
                len_q  <= msg_len > MAX_LEN ? MAX_LEN : msg_len;
                led[1] <= 1'b0;
                led[3] <= 1'b0;
            end
            if (state == LOAD || state == NEXT) begin
                msg_q <= msg_q << DATA_BITS;
                shreg <= msg_q[MW-1 -: DATA_BITS];
                par   <= PARITY_ODD != 0;
                idx   <= state == LOAD ? '0 : idx + 1'b1;
            end
            if (state == DATA && tick) begin
                shreg <= shreg >> 1;
                par   <= par ^ shreg[0];
            end
            if (state == NEXT)
                led[2] <= ~led[2];
            if (abort)
                led[3] <= 1'b1;
            if (state == FINISH)
                led[1] <= 1'b1;
            txd_pin <= state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par : 1'b1;
            busy    <= !(state inside {IDLE, FINISH});
            led[0]  <= !(state inside {IDLE, FINISH});
            done    <= state == FINISH;
        end
    end
endmodule

// File: tb/tb_uart_msg_tx.sv
// tb_uart_msg_tx: self-checking bench for uart_msg_tx across four parameter sets
module tb_uart_msg_tx;
    localparam int CPB = 4;

    // per-instance settings: 0 = 8N1, 1 = 8N1 NUL-stop, 2 = 8E2, 3 = 7O2
    int mb[4] = '{2, 4, 2, 2};
    int db[4] = '{8, 8, 8, 7};
    int pe[4] = '{0, 0, 1, 1};
    int po[4] = '{0, 0, 0, 1};
    int sb[4] = '{1, 1, 2, 2};
    int ns[4] = '{0, 1, 0, 0};
    int lw[4] = '{2, 3, 2, 2};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_v[4];
    logic [15:0] m0, m2;
    logic [31:0] m1;
    logic [13:0] m3;
    logic [1:0]  l0, l2, l3;
    logic [2:0]  l1;
    logic        txd[4], busy[4], done[4];
    logic [3:0]  led[4];
    bit          led2_exp[4];
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_BYTES(2)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .msg(m0), .msg_len(l0),
        .txd_pin(txd[0]), .busy(busy[0]), .done(done[0]), .led(led[0]));
    uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_BYTES(4), .NUL_STOP(1)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .msg(m1), .msg_len(l1),
        .txd_pin(txd[1]), .busy(busy[1]), .done(done[1]), .led(led[1]));
    uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_BYTES(2), .STOP_BITS(2), .PARITY_EN(1)) u2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .msg(m2), .msg_len(l2),
        .txd_pin(txd[2]), .busy(busy[2]), .done(done[2]), .led(led[2]));
    uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_BYTES(2), .DATA_BITS(7), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) u3 (
        .clk(clk), .reset(reset), .start(start_v[3]), .msg(m3), .msg_len(l3),
        .txd_pin(txd[3]), .busy(busy[3]), .done(done[3]), .led(led[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic [31:0] m, input logic [31:0] len, input logic st);
        case (sel)
            0: begin m0 = m[15:0]; l0 = len[1:0]; end
            1: begin m1 = m; l1 = len[2:0]; end
            2: begin m2 = m[15:0]; l2 = len[1:0]; end
            default: begin m3 = m[13:0]; l3 = len[1:0]; end
        endcase
        start_v[sel] = st;
    endtask

    // builds the expected line as a list of bit times, then checks every cycle after the start edge
    task automatic send(input int sel, input logic [31:0] m, input int len, input bit poke);
        bit q[$];
        int l, n, dc, ch;
        bit ab, p;
        l  = len > mb[sel] ? mb[sel] : len;
        n  = 0;
        ab = 1'b0;
        for (int i = 0; i < l; i++) begin
            ch = int'((m >> ((mb[sel] - 1 - i) * db[sel])) & ((32'd1 << db[sel]) - 32'd1));
            if (ns[sel] != 0 && ch == 0) begin
                ab = 1'b1;
                break;
            end
            q.push_back(1'b0);
            p = po[sel] != 0;
            for (int b = 0; b < db[sel]; b++) begin
                q.push_back(ch[b]);
                p ^= ch[b];
            end
            if (pe[sel] != 0) q.push_back(p);
            for (int s = 0; s < sb[sel]; s++) q.push_back(1'b1);
            n++;
        end
        dc = 2 + q.size() * CPB;
        led2_exp[sel] ^= n[0];
        @(negedge clk);
        set_in(sel, m, len, 1'b1);
        @(posedge clk);
        #1 set_in(sel, $urandom, $urandom, 1'b0);
        for (int k = 1; k <= dc + 1; k++) begin
            @(posedge clk);
            #1;
            chk("txd", txd[sel], (k >= 2 && k < dc) ? q[(k - 2) / CPB] : 1'b1);
            chk("busy", busy[sel], k < dc);
            chk("done", done[sel], k == dc);
            if (k == 1) chk("led1_clear", led[sel][1], 1'b0);
            if (k == dc) chk("led_end", led[sel], {ab, led2_exp[sel], 1'b1, 1'b0});
            if (poke) start_v[sel] = (k >= 8 && k < 20);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_in(i, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_txd", txd[i], 1'b1);
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_done", done[i], 1'b0);
            chk("rst_led", led[i], 4'h0);
        end
        reset = 1'b0;
        send(0, 32'h4869, 2, 1'b0);
        send(0, 32'h0000, 0, 1'b0);
        send(1, 32'h41420043, 4, 1'b0);
        send(1, 32'h00414243, 4, 1'b0);
        send(2, 32'h0700, 1, 1'b0);
        send(3, 32'h0380, 1, 1'b0);
        send(0, 32'h4869, 2, 1'b1);
        send(0, 32'h4869, 3, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        start_v[0] = 1'b0;
        led2_exp = '{0, 0, 0, 0};
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_start_busy", busy[0], 1'b0);
            chk("rst_start_txd", txd[0], 1'b1);
        end
        @(negedge clk);
        set_in(0, 32'h4869, 2, 1'b1);
        @(posedge clk);
        #1 set_in(0, 0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mid_rst_txd", txd[0], 1'b1);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_done", done[0], 1'b0);
        chk("mid_rst_led", led[0], 4'h0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("mid_rst_nodone", done[0], 1'b0);
        end
        send(0, 32'h4869, 2, 1'b0);
        for (int r = 0; r < 10; r++) begin
            int sel;
            logic [31:0] m;
            sel = int'($urandom_range(0, 3));
            m = $urandom;
            if (sel == 1 && $urandom_range(0, 1) == 1) m[8 * $urandom_range(0, 3) +: 8] = 8'h00;
            send(sel, m, int'($urandom_range(0, (1 << lw[sel]) - 1)), 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
